// File: rtl/fp_rf_pkg.sv
// Shared constants, access-width enum and pair-index helper for the FP register file.
package fp_rf_pkg;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int MAX_AW       = 16;

   typedef enum logic {ACC_SGL = 1'b0, ACC_DBL = 1'b1} acc_t;

   // Index of the low (hi=0) or high (hi=1) register of the pair containing addr.
   function automatic logic [MAX_AW-1:0] pair_idx(input logic [MAX_AW-1:0] addr, input logic hi);
      return (addr & ~MAX_AW'(1)) | MAX_AW'(hi);
   endfunction
endpackage

// File: rtl/fp_regfile_sb_scoreboard.sv
// Busy-bit scoreboard: issue acceptance, per-port source readiness, set-over-clear priority.
module fp_scoreboard
   import fp_rf_pkg::*;
#(
   parameter  int NUM_REGS  = DEF_NUM_REGS,
   parameter  int NUM_RD    = 2,
   parameter  int ZERO_HARD = 1,
   localparam int AW        = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REGS-1:0]  clrMask,
   input  logic                 issEn,
   input  logic [AW-1:0]        issAddr,
   input  logic                 issDbl,
   input  logic [NUM_RD*AW-1:0] rdAddr,
   input  logic [NUM_RD-1:0]    rdDbl,
   output logic                 issOk,
   output logic                 issIllegal,
   output logic [NUM_RD-1:0]    rdReady
);
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busyEff;
   logic [NUM_REGS-1:0] destMask;
   acc_t                issAcc;

   always_comb begin
      issAcc     = issDbl ? ACC_DBL : ACC_SGL;
      busyEff    = busy & ~clrMask;
      issIllegal = issEn && (issAcc == ACC_DBL) && issAddr[0];
      destMask   = '0;
      if (issEn && !issIllegal) begin
         destMask[issAddr] = 1'b1;
         if (issAcc == ACC_DBL)
            destMask[AW'(pair_idx(MAX_AW'(issAddr), 1'b1))] = 1'b1;
      end
      if (ZERO_HARD != 0)
         destMask[0] = 1'b0;
      issOk = issEn && !issIllegal && ((destMask & busyEff) == '0);
   end

   // Clear is applied first, then the accepted reservation ORed on top, so set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy <= '0;
      else
         busy <= busyEff | (issOk ? destMask : '0);
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : gRd
      logic [AW-1:0]       addr;
      logic [NUM_REGS-1:0] srcMask;
      logic                ready;
      acc_t                acc;

      always_comb begin
         addr    = rdAddr[k*AW +: AW];
         acc     = rdDbl[k] ? ACC_DBL : ACC_SGL;
         srcMask = '0;
         srcMask[addr] = 1'b1;
         if (acc == ACC_DBL)
            srcMask[AW'(pair_idx(MAX_AW'(addr), 1'b1))] = 1'b1;
         ready = !((acc == ACC_DBL) && addr[0]) && ((srcMask & busyEff) == '0);
      end

      assign rdReady[k] = ready;
   end
endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file with write-to-read bypass, single/double access and an issue scoreboard.
module fp_regfile_sb
   import fp_rf_pkg::*;
#(
   parameter  int DATA_W    = DEF_DATA_W,
   parameter  int NUM_REGS  = DEF_NUM_REGS,
   parameter  int NUM_RD    = 2,
   parameter  int ZERO_HARD = 1,
   localparam int AW        = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_RD*AW-1:0]       rd_addr,
   input  logic [NUM_RD-1:0]          rd_dbl,
   output logic [NUM_RD*2*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]          rd_ready,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic                       wr_dbl,
   input  logic [2*DATA_W-1:0]        wr_data,
   input  logic                       iss_en,
   input  logic [AW-1:0]              iss_addr,
   input  logic                       iss_dbl,
   output logic                       iss_ok,
   output logic                       err
);
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] wrMask;
   logic [AW-1:0]       wrHi;
   logic                wrIllegal;
   logic                issIllegal;
   logic                errQ;
   acc_t                wrAcc;

   always_comb begin
      wrAcc     = wr_dbl ? ACC_DBL : ACC_SGL;
      wrIllegal = wr_en && (wrAcc == ACC_DBL) && wr_addr[0];
      wrHi      = AW'(pair_idx(MAX_AW'(wr_addr), 1'b1));
      wrMask    = '0;
      if (wr_en && !wrIllegal) begin
         wrMask[wr_addr] = 1'b1;
         if (wrAcc == ACC_DBL)
            wrMask[wrHi] = 1'b1;
      end
      if (ZERO_HARD != 0)
         wrMask[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++)
            regs[AW'(r)] <= '0;
         errQ <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++)
            if (wrMask[AW'(r)])
               regs[AW'(r)] <= (AW'(r) == wr_addr) ? wr_data[DATA_W-1:0] : wr_data[2*DATA_W-1:DATA_W];
         errQ <= wrIllegal || issIllegal;
      end
   end

   assign err = errQ;

   // Bypassed view of one register: the in-flight writeback half overrides the stored value.
   function automatic logic [DATA_W-1:0] readVal(input logic [AW-1:0] idx);
      if ((ZERO_HARD != 0) && (idx == '0))
         return '0;
      if (wrMask[idx])
         return (idx == wr_addr) ? wr_data[DATA_W-1:0] : wr_data[2*DATA_W-1:DATA_W];
      return regs[idx];
   endfunction

   for (genvar k = 0; k < NUM_RD; k++) begin : gRd
      logic [AW-1:0]       addr;
      logic [AW-1:0]       addrHi;
      logic [2*DATA_W-1:0] portData;
      acc_t                acc;

      always_comb begin
         addr     = rd_addr[k*AW +: AW];
         addrHi   = AW'(pair_idx(MAX_AW'(addr), 1'b1));
         acc      = rd_dbl[k] ? ACC_DBL : ACC_SGL;
         portData = '0;
         if (acc == ACC_SGL)
            portData[DATA_W-1:0] = readVal(addr);
         else if (!addr[0])
            portData = {readVal(addrHi), readVal(addr)};
      end

      assign rd_data[k*2*DATA_W +: 2*DATA_W] = portData;
   end

   fp_scoreboard #(
      .NUM_REGS  (NUM_REGS),
      .NUM_RD    (NUM_RD),
      .ZERO_HARD (ZERO_HARD)
   ) uScoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .clrMask    (wrMask),
      .issEn      (iss_en),
      .issAddr    (iss_addr),
      .issDbl     (iss_dbl),
      .rdAddr     (rd_addr),
      .rdDbl      (rd_dbl),
      .issOk      (iss_ok),
      .issIllegal (issIllegal),
      .rdReady    (rd_ready)
   );
endmodule

// File: tb/tb_fp_regfile_sb.sv
// Directed self-checking bench for fp_regfile_sb with default parameters.
module tb_fp_regfile_sb;
   logic          clk = 1'b0;
   logic          rst_n;
   logic [9:0]    rd_addr;
   logic [1:0]    rd_dbl;
   logic [127:0]  rd_data;
   logic [1:0]    rd_ready;
   logic          wr_en;
   logic [4:0]    wr_addr;
   logic          wr_dbl;
   logic [63:0]   wr_data;
   logic          iss_en;
   logic [4:0]    iss_addr;
   logic          iss_dbl;
   logic          iss_ok;
   logic          err;

   int compared   = 0;
   int mismatched = 0;

   fp_regfile_sb #(
      .DATA_W    (32),
      .NUM_REGS  (32),
      .NUM_RD    (2),
      .ZERO_HARD (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_dbl   (rd_dbl),
      .rd_data  (rd_data),
      .rd_ready (rd_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_dbl   (wr_dbl),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .iss_dbl  (iss_dbl),
      .iss_ok   (iss_ok),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_addr = '0; wr_dbl = 1'b0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; iss_dbl = 1'b0;
   endtask

   task automatic setRead(input logic [4:0] a0, input logic d0, input logic [4:0] a1, input logic d1);
      rd_addr = {a1, a0};
      rd_dbl  = {d1, d0};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      setRead(5'd5, 1'b0, 5'd6, 1'b0);
      #2;
      compared++;
      if (rd_data !== 128'h0) begin mismatched++; $display("FAIL reset_data: got %h want 0", rd_data); end
      compared++;
      if (rd_ready !== 2'b11) begin mismatched++; $display("FAIL reset_ready: got %b want 11", rd_ready); end
      compared++;
      if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
      rst_n = 1'b1;
      iss_en = 1'b1; iss_addr = 5'd5;
      #1;
      compared++;
      if (iss_ok !== 1'b1) begin mismatched++; $display("FAIL issue5_ok: got %b want 1", iss_ok); end
      step();
      idle();
      #1;
      compared++;
      if (rd_ready !== 2'b10) begin mismatched++; $display("FAIL issue5_busy: got %b want 10", rd_ready); end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = {32'h0, 32'h3F800000};
      #1;
      compared++;
      if (rd_data[31:0] !== 32'h3F800000) begin mismatched++; $display("FAIL bypass_data: got %h want 3f800000", rd_data[31:0]); end
      compared++;
      if (rd_ready[0] !== 1'b1) begin mismatched++; $display("FAIL bypass_ready: got %b want 1", rd_ready[0]); end
      step();
      idle();
      #1;
      compared++;
      if (rd_ready !== 2'b11) begin mismatched++; $display("FAIL wb_cleared: got %b want 11", rd_ready); end
      compared++;
      if (rd_data[31:0] !== 32'h3F800000) begin mismatched++; $display("FAIL wb_stored: got %h want 3f800000", rd_data[31:0]); end
   endtask

   task automatic test_double();
      iss_en = 1'b1; iss_addr = 5'd4; iss_dbl = 1'b1;
      #1;
      compared++;
      if (iss_ok !== 1'b1) begin mismatched++; $display("FAIL dbl_issue_ok: got %b want 1", iss_ok); end
      step();
      iss_dbl = 1'b0; iss_addr = 5'd5;
      setRead(5'd4, 1'b1, 5'd4, 1'b0);
      #1;
      compared++;
      if (iss_ok !== 1'b0) begin mismatched++; $display("FAIL waw_stall: got %b want 0", iss_ok); end
      compared++;
      if (rd_ready !== 2'b00) begin mismatched++; $display("FAIL dbl_busy_ready: got %b want 00", rd_ready); end
      step();
      idle();
      wr_en = 1'b1; wr_addr = 5'd4; wr_dbl = 1'b1; wr_data = {32'h40000000, 32'h3F800000};
      #1;
      compared++;
      if (rd_data[63:0] !== 64'h400000003F800000) begin mismatched++; $display("FAIL dbl_bypass: got %h want 400000003f800000", rd_data[63:0]); end
      compared++;
      if (rd_ready !== 2'b11) begin mismatched++; $display("FAIL dbl_wb_ready: got %b want 11", rd_ready); end
      step();
      idle();
      #1;
      compared++;
      if (rd_data[63:0] !== 64'h400000003F800000) begin mismatched++; $display("FAIL dbl_stored: got %h want 400000003f800000", rd_data[63:0]); end
      compared++;
      if (rd_data[95:64] !== 32'h3F800000) begin mismatched++; $display("FAIL sgl_reg4: got %h want 3f800000", rd_data[95:64]); end
   endtask

   task automatic test_illegal();
      iss_en = 1'b1; iss_addr = 5'd3; iss_dbl = 1'b1;
      #1;
      compared++;
      if (iss_ok !== 1'b0) begin mismatched++; $display("FAIL odd_issue_ok: got %b want 0", iss_ok); end
      step();
      idle();
      setRead(5'd3, 1'b0, 5'd4, 1'b0);
      wr_en = 1'b1; wr_addr = 5'd7; wr_dbl = 1'b1; wr_data = {32'hDEADBEEF, 32'h12345678};
      #1;
      compared++;
      if (err !== 1'b1) begin mismatched++; $display("FAIL odd_issue_err: got %b want 1", err); end
      compared++;
      if (rd_ready !== 2'b11) begin mismatched++; $display("FAIL odd_issue_nores: got %b want 11", rd_ready); end
      step();
      idle();
      setRead(5'd7, 1'b0, 5'd8, 1'b0);
      #1;
      compared++;
      if (err !== 1'b1) begin mismatched++; $display("FAIL odd_wr_err: got %b want 1", err); end
      compared++;
      if (rd_data !== 128'h0) begin mismatched++; $display("FAIL odd_wr_nochange: got %h want 0", rd_data); end
      setRead(5'd5, 1'b1, 5'd5, 1'b0);
      #1;
      compared++;
      if (rd_data[63:0] !== 64'h0) begin mismatched++; $display("FAIL odd_rd_data: got %h want 0", rd_data[63:0]); end
      compared++;
      if (rd_ready !== 2'b10) begin mismatched++; $display("FAIL odd_rd_ready: got %b want 10", rd_ready); end
      step();
      compared++;
      if (err !== 1'b0) begin mismatched++; $display("FAIL err_pulse_end: got %b want 0", err); end
   endtask

   task automatic test_set_wins();
      iss_en = 1'b1; iss_addr = 5'd9;
      step();
      idle();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = {32'h0, 32'hCAFEF00D};
      iss_en = 1'b1; iss_addr = 5'd9;
      #1;
      compared++;
      if (iss_ok !== 1'b1) begin mismatched++; $display("FAIL setwins_ok: got %b want 1", iss_ok); end
      step();
      idle();
      setRead(5'd9, 1'b0, 5'd4, 1'b1);
      #1;
      compared++;
      if (rd_data[31:0] !== 32'hCAFEF00D) begin mismatched++; $display("FAIL setwins_data: got %h want cafef00d", rd_data[31:0]); end
      compared++;
      if (rd_ready !== 2'b10) begin mismatched++; $display("FAIL setwins_busy: got %b want 10", rd_ready); end
   endtask

   task automatic test_zero_hard();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = {32'h0, 32'hFFFFFFFF};
      setRead(5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      compared++;
      if (rd_data !== 128'h0) begin mismatched++; $display("FAIL zero_bypass: got %h want 0", rd_data); end
      step();
      idle();
      iss_en = 1'b1; iss_addr = 5'd0;
      #1;
      compared++;
      if (rd_data !== 128'h0) begin mismatched++; $display("FAIL zero_stored: got %h want 0", rd_data); end
      compared++;
      if (iss_ok !== 1'b1) begin mismatched++; $display("FAIL zero_issue_ok: got %b want 1", iss_ok); end
      step();
      idle();
      wr_en = 1'b1; wr_addr = 5'd0; wr_dbl = 1'b1; wr_data = {32'h11111111, 32'hFFFFFFFF};
      setRead(5'd0, 1'b1, 5'd1, 1'b0);
      #1;
      compared++;
      if (rd_ready !== 2'b11) begin mismatched++; $display("FAIL zero_never_busy: got %b want 11", rd_ready); end
      step();
      idle();
      #1;
      compared++;
      if (rd_data[63:0] !== 64'h1111111100000000) begin mismatched++; $display("FAIL zero_pair: got %h want 1111111100000000", rd_data[63:0]); end
      compared++;
      if (rd_data[95:64] !== 32'h11111111) begin mismatched++; $display("FAIL reg1_written: got %h want 11111111", rd_data[95:64]); end
   endtask

   task automatic test_async_reset();
      setRead(5'd9, 1'b0, 5'd4, 1'b1);
      #1;
      compared++;
      if (rd_data[31:0] !== 32'hCAFEF00D || rd_ready !== 2'b10) begin
         mismatched++; $display("FAIL prereset_state: got %h/%b want cafef00d/10", rd_data[31:0], rd_ready);
      end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      compared++;
      if (rd_data !== 128'h0) begin mismatched++; $display("FAIL async_rst_data: got %h want 0", rd_data); end
      compared++;
      if (rd_ready !== 2'b11) begin mismatched++; $display("FAIL async_rst_ready: got %b want 11", rd_ready); end
      rst_n = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = {32'h0, 32'h00000055};
      step();
      idle();
      #1;
      compared++;
      if (rd_data[31:0] !== 32'h00000055 || rd_ready[0] !== 1'b1) begin
         mismatched++; $display("FAIL post_rst_write: got %h/%b want 00000055/1", rd_data[31:0], rd_ready[0]);
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_double();
      test_illegal();
      test_set_wins();
      test_zero_hard();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
Parametrised floating-point register file with an integrated scoreboard, for the multi-cycle FPU datapath. It supports N read ports, one writeback port, and same-cycle write-to-read bypass. Single or double (even/odd pair) precision is selectable per access. A per-register busy bit is set when an FP instruction issues and cleared at writeback, so decode can stall on RAW/WAW hazards.

Parameters:
DATA_W, 32, width of one register
NUM_REGS, 32, register count (power of 2, >=4)
NUM_RD, 2, number of read ports
ZERO_HARD, 1, 1 = register 0 reads 0 and ignores writes/issues
AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
rd_dbl  in  NUM_RD  port k reads pair {reg[a+1],reg[a]}
rd_data  out  NUM_RD*2*DATA_W  read data, port k at [k*2*DATA_W +: 2*DATA_W]; upper half 0 when single
rd_ready  out  NUM_RD  port k source(s) not busy (or being written back this cycle)
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback address
wr_dbl  in  1  write pair
wr_data  in  2*DATA_W  writeback data, low half -> reg[a], high half -> reg[a+1]
iss_en  in  1  instruction issue, reserve destination
iss_addr  in  AW  destination to reserve
iss_dbl  in  1  reserve pair
iss_ok  out  1  issue accepted this cycle
err  out  1  registered 1-cycle pulse on illegal access

Behaviour:
- Reset (async, rst_n=0): all registers 0, all busy bits 0, err 0. Comb outputs then give rd_data=0, rd_ready all 1, iss_ok=iss_en and no dest busy.
- Write: on rising clk with wr_en, reg[a] <= low half. If wr_dbl, reg[a+1] <= high half. Busy bits of written regs are cleared.
- Read: combinational, 0-cycle latency. Bypass: if wr_en targets a read register this cycle, rd_data returns wr_data (per half), not the stored value.
- Double access needs an even address. Odd rd_addr with rd_dbl returns 0 and sets rd_ready=0. Odd wr_addr/iss_addr with dbl means the op is ignored and err pulses the next cycle.
- ZERO_HARD=1: reg 0 always reads 0 and is never busy. Writes/issues to reg 0 (single) are silently dropped, and iss_ok still asserts. Double to pair 0/1: only reg1 is written/reserved.
- rd_ready[k] = 0 iff any source register is busy and not being cleared by this cycle's wr_en.
- iss_ok = iss_en and no dest register busy after this cycle's writeback clear. On iss_ok, the dest busy bit(s) are set at the clock edge. iss_en against a busy dest gives iss_ok=0, no state change, no err (normal stall).
- Same cycle wr_en clear and accepted issue to the same reg: set wins, so the reg ends busy.
- wr_en to a non-busy register is legal (e.g. move-to-FP) and writes normally.
- Reset asserted mid-operation clears everything immediately. In-flight writebacks after reset are honoured as plain writes.

Decomposition:
- Package fp_rf_pkg: default DATA_W/NUM_REGS constants, function pair_idx(addr, hi), and enum acc_t {ACC_SGL, ACC_DBL}.
- Sub-module fp_scoreboard: busy vector, iss_ok/rd_ready logic, and set/clear priority. It is instantiated once.
- The data array, bypass and read muxes stay in the top module.

Test Plan:
1. Reset then read ports 0/1 at addr 5,6 -> rd_data=0, rd_ready=2'b11. Issue addr 5 -> iss_ok=1, next cycle rd_ready[0]=0.
2. Busy reg 5, wr_en addr5 data 0x3F800000 -> same cycle rd_data[31:0]=0x3F800000 (bypass) and rd_ready[0]=1. Next cycle busy cleared.
3. Issue dbl addr 4 -> regs 4,5 busy. Second issue addr 5 -> iss_ok=0. Wr dbl addr4 data {0x40000000,0x3F800000} -> rd_dbl addr4 returns 0x400000003F800000.
4. Issue dbl addr 3 -> iss_ok=0, err=1 the next cycle. Wr dbl addr 7 -> no register changes, err pulse.
5. Same cycle: wr_en addr 9 (busy) and iss_en addr 9 -> iss_ok=1, reg9 holds new data and remains busy.
6. Write reg0 = 0xFFFFFFFF (ZERO_HARD=1) -> read 0 returns 0. Drop rst_n mid-sequence -> all rd_data=0, rd_ready all 1 immediately, without waiting for clk.
